// File: rtl/ram8_byte_ctrl_if.sv
// Byte-stream command/readback bus plus the RAM8 port, bundled for ram8_byte_ctrl.
// The slave modport is the controller's view; the master modport is the driving side.
interface ram8_byte_ctrl_if;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic        out_valid;
  logic [7:0]  out_data;
  logic        out_ready;
  logic        busy;
  logic        ram_en;
  logic [3:0]  ram_we;
  logic [2:0]  ram_a;
  logic [31:0] ram_di;
  logic [31:0] ram_do;

  modport slave (
    input  in_valid, in_data, out_ready, ram_do,
    output in_ready, out_valid, out_data, busy, ram_en, ram_we, ram_a, ram_di
  );

  modport master (
    output in_valid, in_data, out_ready, ram_do,
    input  in_ready, out_valid, out_data, busy, ram_en, ram_we, ram_a, ram_di
  );
endinterface

// File: rtl/ram8_byte_ctrl.sv
// Byte-serial front end for an 8x32 RAM8 macro: command byte, then 4 write bytes
// or 4 readback bytes, LSB first. Every output comes from a register or the state.
module ram8_byte_ctrl (
  input  logic            CLK,
  input  logic            RST_N,
  ram8_byte_ctrl_if.slave bus
);

  typedef enum logic [2:0] {IDLE, WDATA, WISSUE, RISSUE, RWAIT, RSEND} state_t;

  state_t      state_q, state_d;
  logic        live_q;
  logic [2:0]  addr_q, addr_d;
  logic [3:0]  mask_q, mask_d;
  logic [31:0] di_q, di_d;
  logic [31:0] sh_q, sh_d;
  logic [1:0]  cnt_q, cnt_d;
  logic        in_rdy, in_acc, out_acc;

  // live_q keeps in_ready low during reset and raises it on the first edge after release
  assign in_rdy  = live_q && (state_q == IDLE || state_q == WDATA);
  assign in_acc  = bus.in_valid && in_rdy;
  assign out_acc = (state_q == RSEND) && bus.out_ready;

  assign bus.in_ready  = in_rdy;
  assign bus.out_valid = (state_q == RSEND);
  assign bus.out_data  = sh_q[7:0];
  assign bus.busy      = (state_q != IDLE);
  assign bus.ram_en    = (state_q == WISSUE) || (state_q == RISSUE);
  assign bus.ram_we    = (state_q == WISSUE) ? mask_q : 4'b0000;
  assign bus.ram_a     = addr_q;
  assign bus.ram_di    = di_q;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= IDLE;
      live_q  <= 1'b0;
      addr_q  <= '0;
      mask_q  <= '0;
      di_q    <= '0;
      sh_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      live_q  <= 1'b1;
      addr_q  <= addr_d;
      mask_q  <= mask_d;
      di_q    <= di_d;
      sh_q    <= sh_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    mask_d  = mask_q;
    di_d    = di_q;
    sh_d    = sh_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (in_acc) begin
          addr_d  = bus.in_data[2:0];
          mask_d  = bus.in_data[6:3];
          state_d = bus.in_data[7] ? WDATA : RISSUE;
        end
      end
      WDATA: begin
        if (in_acc) begin
          di_d[{cnt_q, 3'b000} +: 8] = bus.in_data;
          cnt_d = cnt_q + 2'd1;
          // an all-zero lane mask skips the RAM access entirely
          if (cnt_q == 2'd3) state_d = (mask_q != 4'b0000) ? WISSUE : IDLE;
        end
      end
      WISSUE: state_d = IDLE;
      RISSUE: state_d = RWAIT;
      RWAIT: begin
        sh_d    = bus.ram_do;
        state_d = RSEND;
      end
      RSEND: begin
        if (out_acc) begin
          sh_d  = sh_q >> 8;
          cnt_d = cnt_q + 2'd1;
          if (cnt_q == 2'd3) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: doc/ram8_byte_ctrl.md
RAM8_BYTE_CTRL -- requirements
Module: ram8_byte_ctrl

Interface
REQ-001 The block SHALL have no parameters; the word width is fixed at 32 bits, the address at 3 bits, and the byte-lane mask at 4 bits.
REQ-002 The ports SHALL be as follows (name, direction, width, meaning):
- CLK, in, 1: single clock, rising edge.
- RST_N, in, 1: reset, asynchronous, active-low.
- in_valid, in, 1: command/data byte valid.
- in_data, in, 8: command/data byte.
- in_ready, out, 1: byte accepted when in_valid&in_ready at a CLK edge.
- out_valid, out, 1: readback byte valid.
- out_data, out, 8: readback byte.
- out_ready, in, 1: consumer accepts the byte when out_valid&out_ready.
- busy, out, 1: high whenever the state is not IDLE.
- ram_en, out, 1: drives RAM8 EN0.
- ram_we, out, 4: drives RAM8 WE0.
- ram_a, out, 3: drives RAM8 A0.
- ram_di, out, 32: drives RAM8 Di0.
- ram_do, in, 32: from RAM8 Do0; registered, valid one cycle after ram_en; zero when ram_en was low.
REQ-003 The clock SHALL be a single clock CLK, and the reset SHALL be RST_N, asynchronous and active-low.
REQ-004 All outputs SHALL be driven from registers or decoded from state only, with no combinational path from any input to any output.

Function
REQ-005 A command byte SHALL be decoded as bit7 = op (1 write, 0 read), bits6:3 = byte-lane mask, and bits2:0 = address.
REQ-006 The state machine SHALL have the states IDLE, WDATA, WISSUE, RISSUE, RWAIT and RSEND.
REQ-007 In IDLE, in_ready SHALL be 1; an accepted command SHALL latch the address and mask, then go to WDATA for a write or RISSUE for a read.
REQ-008 In WDATA, in_ready SHALL be 1 and the block SHALL accept exactly 4 bytes, LSB first, into ram_di[8k+7:8k], where k is a 2-bit counter that wraps to 0 after the 4th byte.
REQ-009 When the 4th data byte is accepted with a nonzero mask, the state SHALL go to WISSUE; with a zero mask, it SHALL go directly to IDLE and no RAM access SHALL occur.
REQ-010 WISSUE SHALL last 1 cycle with ram_en=1 and ram_we=mask, then return to IDLE.
REQ-011 RISSUE SHALL last 1 cycle with ram_en=1 and ram_we=0, then go to RWAIT.
REQ-012 RWAIT SHALL last 1 cycle, with ram_en=0, and SHALL capture ram_do into a 32-bit shift register at its closing edge.
REQ-013 In RSEND, out_valid SHALL be 1 and out_data SHALL be the shift register [7:0]; on each accepted byte the register SHALL shift right by 8; after the 4th accepted byte the state SHALL return to IDLE.
REQ-014 out_data SHALL be held stable while out_valid=1 and out_ready=0; backpressure of any length SHALL be tolerated.
REQ-015 in_ready SHALL be 0 in WISSUE, RISSUE, RWAIT and RSEND, and bytes presented in those states SHALL NOT be consumed.
REQ-016 Outside WISSUE and RISSUE, ram_en SHALL be 0 and ram_we SHALL be 0.
REQ-017 ram_a and ram_di SHALL hold their last values while idle.
REQ-018 With no stalls, write latency SHALL be: command at cycle 0, data bytes at cycles 1-4, WISSUE at cycle 5, in_ready=1 at cycle 6.
REQ-019 With no stalls, read latency SHALL be: command at cycle 0, RISSUE at cycle 1, RWAIT at cycle 2, bytes at cycles 3-6, in_ready=1 at cycle 7.
REQ-020 in_valid gaps in WDATA SHALL stall collection without a timeout.

Reset
REQ-021 While RST_N=0, the state SHALL be IDLE and all outputs SHALL be 0: in_ready, out_valid, out_data, busy, ram_en, ram_we, ram_a and ram_di.
REQ-022 The byte counter and the shift register SHALL also be cleared while RST_N=0.
REQ-023 After RST_N deasserts, in_ready SHALL be 1 from the first CLK edge.
REQ-024 Reset asserted mid-operation SHALL abandon the operation: ram_en falls immediately, no partial write is issued, and no stale readback byte is emitted afterwards.

Verification
REQ-025 Write then read: send bytes 0xF9, 0x11, 0x22, 0x33, 0x44 -> one cycle with ram_en=1, ram_we=0xF, ram_a=1, ram_di=0x44332211; then send 0x01 -> out bytes 0x11, 0x22, 0x33, 0x44.
REQ-026 Partial mask: write 0x8A (mask 0001, address 2) with data AA BB CC DD over a word previously 0 -> ram_we=0x1; a readback of address 2 returns AA 00 00 00.
REQ-027 Zero mask: send 0x83 plus 4 data bytes -> ram_en stays 0 throughout and busy falls 1 cycle after the 4th byte.
REQ-028 Backpressure: a read with out_ready=0 for 10 cycles, then toggling -> out_data is stable while stalled, exactly 4 bytes are emitted in order, and in_ready stays 0 until the last byte is accepted.
REQ-029 Reset mid-write: RST_N low after 2 data bytes -> all outputs are 0 immediately, no ram_en pulse occurs, and the next command is decoded correctly.
REQ-030 Reset in RSEND: RST_N low after 1 byte sent -> out_valid=0, and after release the block is idle with in_ready=1.
